// File: rtl/dca_step_sched_pkg.sv
// Shared definitions for the GEMM step scheduler: step field positions, loader
// indices and the scheduler state encoding.
package dca_step_sched_pkg;

  localparam int unsigned FieldLoadA   = 0;
  localparam int unsigned FieldLoadB   = 1;
  localparam int unsigned FieldLoadC   = 2;
  localparam int unsigned FieldCompute = 3;
  localparam int unsigned FieldStore   = 4;
  localparam int unsigned FieldLast    = 5;
  localparam int unsigned NumFields    = 6;

  localparam int unsigned LoaderA    = 0;
  localparam int unsigned LoaderB    = 1;
  localparam int unsigned LoaderC    = 2;
  localparam int unsigned NumLoaders = 3;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitLoad  = 3'd1,
    StIssueCmd  = 3'd2,
    StWaitDone  = 3'd3,
    StWaitStore = 3'd4
  } state_e;

  // Loader select mask, indexed by loader number.
  function automatic logic [NumLoaders-1:0] load_sel(input logic [NumFields-1:0] step);
    logic [NumLoaders-1:0] sel;
    sel          = '0;
    sel[LoaderA] = step[FieldLoadA];
    sel[LoaderB] = step[FieldLoadB];
    sel[LoaderC] = step[FieldLoadC];
    return sel;
  endfunction

endpackage

// File: rtl/dca_gemm_step_scheduler_if.sv
// Handshake bundle between the step scheduler (master) and the step FIFO,
// matrix loaders, compute engine and store path (slave).
interface dca_gemm_step_scheduler_if #(
  parameter int unsigned BW_STEP_INST = 8
);
  logic                    step_rready;
  logic                    step_rrequest;
  logic [BW_STEP_INST-1:0] step_rdata;
  logic [2:0]              loadreg_rready;
  logic [2:0]              loadreg_rrequest;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_done;
  logic                    storereg_wready;
  logic                    storereg_wrequest;

  modport master (
    input  step_rready, step_rdata, loadreg_rready, cmd_ready, cmd_done, storereg_wready,
    output step_rrequest, loadreg_rrequest, cmd_valid, storereg_wrequest
  );

  modport slave (
    output step_rready, step_rdata, loadreg_rready, cmd_ready, cmd_done, storereg_wready,
    input  step_rrequest, loadreg_rrequest, cmd_valid, storereg_wrequest
  );
endinterface

// File: rtl/dca_step_sched_perf_counter.sv
// Completed-step and stall counters for the step scheduler; both wrap freely.
module dca_step_sched_perf_counter #(
  parameter int unsigned BW_PERF_COUNT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_done,
  input  logic                     stall,
  output logic [BW_PERF_COUNT-1:0] step_count,
  output logic [BW_PERF_COUNT-1:0] stall_count
);

  logic [BW_PERF_COUNT-1:0] step_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (step_done) step_count_q  <= step_count_q + 1'b1;
      if (stall)     stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign step_count  = step_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: rtl/dca_gemm_step_scheduler.sv
// Sequences one GEMM step at a time: fetch, wait for loads, issue compute, store.
// Define DCA_STEP_SCHED_PERF_COUNTER_EN to build the performance counters.
module dca_gemm_step_scheduler
  import dca_step_sched_pkg::*;
#(
  parameter int unsigned BW_STEP_INST  = 8,
  parameter int unsigned BW_PERF_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         enable,
  dca_gemm_step_scheduler_if.master    bus,
  output logic                         busy,
  output logic                         done,
  output logic [BW_PERF_COUNT-1:0]     perf_step_count,
  output logic [BW_PERF_COUNT-1:0]     perf_stall_count
);

  state_e                state_q, state_d;
  logic [NumFields-1:0]  step_q, step_d;
  logic [BW_STEP_INST-1:0] step_raw;
  logic [NumLoaders-1:0] sel;
  logic                  load_met;
  logic                  pop, cmd_valid, store_req, step_fin;
  logic [NumLoaders-1:0] load_req;
  logic                  unused_step_bits;

  // Only the low field bits carry meaning; the rest are accepted and dropped.
  assign step_raw         = bus.step_rdata;
  assign unused_step_bits = ^step_raw;

  assign sel      = load_sel(step_q);
  assign load_met = (bus.loadreg_rready & sel) == sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pop       = 1'b0;
    load_req  = '0;
    cmd_valid = 1'b0;
    store_req = 1'b0;
    step_fin  = 1'b0;
    if (rst || clear) begin
      state_d = StIdle;
      step_d  = '0;
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (bus.step_rready) begin
            pop     = 1'b1;
            step_d  = step_raw[NumFields-1:0];
            state_d = StWaitLoad;
          end
        end
        StWaitLoad: begin
          if (load_met) begin
            load_req = sel;
            if (step_q[FieldCompute])    state_d = StIssueCmd;
            else if (step_q[FieldStore]) state_d = StWaitStore;
            else begin
              state_d  = StIdle;
              step_fin = 1'b1;
            end
          end
        end
        StIssueCmd: begin
          cmd_valid = 1'b1;
          if (bus.cmd_ready) state_d = StWaitDone;
        end
        StWaitDone: begin
          if (bus.cmd_done) begin
            if (step_q[FieldStore]) state_d = StWaitStore;
            else begin
              state_d  = StIdle;
              step_fin = 1'b1;
            end
          end
        end
        StWaitStore: begin
          if (bus.storereg_wready) begin
            store_req = 1'b1;
            state_d   = StIdle;
            step_fin  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.step_rrequest     = pop;
  assign bus.loadreg_rrequest  = load_req;
  assign bus.cmd_valid         = cmd_valid;
  assign bus.storereg_wrequest = store_req;
  assign busy                  = (state_q != StIdle) && !rst;
  assign done                  = step_fin && step_q[FieldLast];

`ifdef DCA_STEP_SCHED_PERF_COUNTER_EN
  logic                     stall_evt;
  logic [BW_PERF_COUNT-1:0] step_cnt, stall_cnt;

  assign stall_evt = enable && !clear && !rst &&
                     (((state_q == StWaitLoad) && !load_met) ||
                      ((state_q == StWaitStore) && !bus.storereg_wready));

  dca_step_sched_perf_counter #(
    .BW_PERF_COUNT(BW_PERF_COUNT)
  ) u_perf_counter (
    .clk        (clk),
    .rst        (rst),
    .step_done  (step_fin),
    .stall      (stall_evt),
    .step_count (step_cnt),
    .stall_count(stall_cnt)
  );

  // Outputs read zero while reset is held, even before the counters clear.
  assign perf_step_count  = rst ? '0 : step_cnt;
  assign perf_stall_count = rst ? '0 : stall_cnt;
`else
  assign perf_step_count  = '0;
  assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_dca_gemm_step_scheduler.sv
// Directed bench for dca_gemm_step_scheduler: a task-list model of step progress is
// compared against the DUT every cycle, plus literal event-timing expectations.
module tb_dca_gemm_step_scheduler;

`ifdef DCA_STEP_SCHED_PERF_COUNTER_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        clear  = 1'b0;
  logic        enable = 1'b1;
  logic        busy, done;
  logic [31:0] perf_step_count, perf_stall_count;

  dca_gemm_step_scheduler_if #(.BW_STEP_INST(8)) bus ();

  dca_gemm_step_scheduler #(
    .BW_STEP_INST (8),
    .BW_PERF_COUNT(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .enable          (enable),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .perf_step_count (perf_step_count),
    .perf_stall_count(perf_stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pop_c[$], ld_c[$], ld_v[$], acc_c[$], st_c[$], dn_c[$];
  int cv_n     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  // Model: a fetched step is a list of outstanding jobs done strictly in order
  // (loads, command issue, command completion, store), one job per enabled cycle.
  bit          m_have = 1'b0;
  logic [5:0]  m_step = '0;
  bit          m_loaded, m_issued, m_computed;
  int unsigned m_steps = 0, m_stalls = 0;

  always @(negedge clk) begin : cmp
    logic       e_pop, e_cv, e_st, e_dn, e_busy, fin;
    logic [2:0] e_ld, sel;
    logic [31:0] e_ps, e_pt;
    e_pop = 0; e_cv = 0; e_st = 0; e_dn = 0; e_ld = '0; fin = 0;
    e_busy = m_have && !rst;
    e_ps   = (PerfEn && !rst) ? m_steps  : 32'd0;
    e_pt   = (PerfEn && !rst) ? m_stalls : 32'd0;
    if (rst) begin
      m_have = 0; m_step = '0; m_steps = 0; m_stalls = 0;
    end else if (clear) begin
      m_have = 0;
    end else if (enable) begin
      if (!m_have) begin
        if (bus.step_rready) begin
          e_pop = 1; m_have = 1; m_step = bus.step_rdata[5:0];
          m_loaded = 0; m_issued = 0; m_computed = 0;
        end
      end else if (!m_loaded) begin
        sel = m_step[2:0];
        if ((bus.loadreg_rready & sel) == sel) begin
          e_ld = sel; m_loaded = 1;
          fin = !m_step[3] && !m_step[4];
        end else m_stalls++;
      end else if (m_step[3] && !m_issued) begin
        e_cv = 1;
        if (bus.cmd_ready) m_issued = 1;
      end else if (m_step[3] && !m_computed) begin
        if (bus.cmd_done) begin
          m_computed = 1;
          fin = !m_step[4];
        end
      end else begin
        if (bus.storereg_wready) begin
          e_st = 1; fin = 1;
        end else m_stalls++;
      end
    end
    if (fin) begin
      e_dn = m_step[5]; m_have = 0; m_steps++;
    end
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("step_rrequest", {31'd0, bus.step_rrequest}, {31'd0, e_pop});
    check("loadreg_rrequest", {29'd0, bus.loadreg_rrequest}, {29'd0, e_ld});
    check("cmd_valid", {31'd0, bus.cmd_valid}, {31'd0, e_cv});
    check("storereg_wrequest", {31'd0, bus.storereg_wrequest}, {31'd0, e_st});
    check("done", {31'd0, done}, {31'd0, e_dn});
    check("perf_step_count", perf_step_count, e_ps);
    check("perf_stall_count", perf_stall_count, e_pt);
    if (bus.step_rrequest) pop_c.push_back(cyc);
    if (bus.loadreg_rrequest != 0) begin
      ld_c.push_back(cyc); ld_v.push_back(int'(bus.loadreg_rrequest));
    end
    if (bus.cmd_valid && bus.cmd_ready) acc_c.push_back(cyc);
    if (bus.cmd_valid) cv_n++;
    if (bus.storereg_wrequest) st_c.push_back(cyc);
    if (done) dn_c.push_back(cyc);
    cyc++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    pop_c.delete(); ld_c.delete(); ld_v.delete(); acc_c.delete();
    st_c.delete(); dn_c.delete(); cv_n = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear = 0; enable = 1;
    bus.step_rready = 0; bus.step_rdata = '0; bus.loadreg_rready = '0;
    bus.cmd_ready = 0; bus.cmd_done = 0; bus.storereg_wready = 0;
    tick(2);
    rst = 0;
    clear_logs();
  endtask

  // Cycle of event i in queue q relative to the first pop, or -1 if absent.
  function automatic int rel(input int q[$], input int i);
    if (i >= q.size() || pop_c.size() == 0) return -1;
    return q[i] - pop_c[0];
  endfunction

  // Pop one step, then stop offering further steps.
  task automatic fetch(input logic [7:0] step);
    bus.step_rdata = step; bus.step_rready = 1;
    tick();
    bus.step_rready = 0;
  endtask

  initial begin
    bus.step_rready = 1; bus.step_rdata = 8'hFF; bus.loadreg_rready = 3'b111;
    bus.cmd_ready = 1; bus.cmd_done = 1; bus.storereg_wready = 1;
    tick(2);
    check("rst_no_pop", pop_c.size(), 0);
    check("rst_busy", {31'd0, busy}, 0);

    // Full step with every ready immediately available.
    do_reset();
    bus.loadreg_rready = 3'b111; bus.cmd_ready = 1; bus.storereg_wready = 1;
    fetch(8'h3F);
    tick(4);
    bus.cmd_done = 1;
    tick();
    bus.cmd_done = 0;
    tick(3);
    check("full_pops", pop_c.size(), 1);
    check("full_ld_val", ld_v.size() == 1 ? ld_v[0] : -1, 7);
    check("full_ld_cyc", rel(ld_c, 0), 1);
    check("full_acc_cyc", rel(acc_c, 0), 2);
    check("full_acc_n", acc_c.size(), 1);
    check("full_st_cyc", rel(st_c, 0), 6);
    check("full_dn_cyc", rel(dn_c, 0), 6);
    check("full_perf_steps", perf_step_count, PerfEn ? 1 : 0);

    // Load A only, its loader ready five cycles late.
    do_reset();
    fetch(8'h01);
    tick(5);
    bus.loadreg_rready = 3'b001;
    tick(3);
    check("lda_ld_n", ld_v.size(), 1);
    check("lda_ld_val", ld_v.size() == 1 ? ld_v[0] : -1, 1);
    check("lda_ld_cyc", rel(ld_c, 0), 6);
    check("lda_stalls", perf_stall_count, PerfEn ? 5 : 0);
    check("lda_no_done", dn_c.size(), 0);

    // Three queued NOPs, loaders all ready so a stray load pulse would show.
    do_reset();
    bus.loadreg_rready = 3'b111; bus.storereg_wready = 1;
    bus.step_rdata = 8'h00; bus.step_rready = 1;
    tick(5);
    bus.step_rready = 0;
    tick(3);
    check("nop_pops", pop_c.size(), 3);
    check("nop_pop1", rel(pop_c, 1), 2);
    check("nop_pop2", rel(pop_c, 2), 4);
    check("nop_quiet", ld_c.size() + acc_c.size() + st_c.size() + dn_c.size(), 0);

    // Clear while waiting for compute, then a stray cmd_done.
    do_reset();
    bus.loadreg_rready = 3'b111; bus.cmd_ready = 1; bus.storereg_wready = 1;
    fetch(8'h3F);
    tick(2);
    clear = 1;
    tick();
    clear = 0; bus.cmd_done = 1;
    tick();
    bus.cmd_done = 0;
    tick(3);
    check("clr_acc_n", acc_c.size(), 1);
    check("clr_no_store", st_c.size(), 0);
    check("clr_no_done", dn_c.size(), 0);
    check("clr_idle", {31'd0, busy}, 0);

    // Enable dropped for four cycles while issuing a command.
    do_reset();
    fetch(8'h08);
    tick(2);
    enable = 0;
    tick(4);
    enable = 1;
    tick();
    bus.cmd_ready = 1;
    tick();
    bus.cmd_ready = 0;
    tick();
    bus.cmd_done = 1;
    tick();
    bus.cmd_done = 0;
    tick(2);
    check("en_acc_n", acc_c.size(), 1);
    check("en_acc_cyc", rel(acc_c, 0), 8);
    check("en_cv_cycles", cv_n, 3);
    check("en_idle", {31'd0, busy}, 0);

    // Reset while waiting to store.
    do_reset();
    fetch(8'h30);
    tick(2);
    rst = 1; bus.storereg_wready = 1;
    tick();
    rst = 0;
    check("rst_ws_busy", {31'd0, busy}, 0);
    tick(3);
    check("rst_ws_no_store", st_c.size(), 0);
    check("rst_ws_no_done", dn_c.size(), 0);
    check("rst_ws_stalls", perf_stall_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
